// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states,
// fault-flag bit positions and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam int FLT_MISALIGNED = 0;
    localparam int FLT_RANGE      = 1;
    localparam int FLT_W          = 2;

    // The reserved size encoding is reported as an alignment fault.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane selection shared by load extraction and store merging.
// One mask and shift amount drive both directions.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [1:0]  lane;
    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] field;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        lane = 2'd0;
        mask = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF;
                lane = BIG_ENDIAN ? 2'd3 - addr_lo : addr_lo;
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF;
                lane = BIG_ENDIAN ? 2'd2 - {addr_lo[1], 1'b0} : {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
        shamt = {lane, 3'b000};

        field     = (word >> shamt) & mask;
        load_data = field;
        if (sign_ext) begin
            case (size)
                SZ_BYTE: load_data = {{24{field[7]}}, field[7:0]};
                SZ_HALF: load_data = {{16{field[15]}}, field[15:0]};
                default: ;
            endcase
        end

        store_word = (word & ~(mask << shamt)) | ((store_data & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator: checks alignment and range, then drives
// word accesses to data memory, using read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_range_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    lsu_state_e        state, state_next;
    logic [31:0]       addr_q, wdata_q, buf_q;
    logic [1:0]        size_q;
    logic              signed_q, write_q;
    logic [FLT_W-1:0]  flt_q;
    logic              req_mis, req_oor;
    logic [31:0]       load_data;

    assign req_mis = is_misaligned(req_size, req_addr[1:0]);
    assign req_oor = (req_addr >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            flt_q    <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                addr_q                <= req_addr;
                wdata_q               <= req_wdata;
                size_q                <= req_size;
                signed_q              <= req_signed;
                write_q               <= req_write;
                flt_q[FLT_MISALIGNED] <= req_mis;
                flt_q[FLT_RANGE]      <= !req_mis && req_oor;
            end
            if (state == RD) buf_q <= mem_read_data;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis || req_oor)                      state_next = RESP;
                    else if (!req_write || req_size != SZ_WORD) state_next = RD;
                    else                                         state_next = WR;
                end
            end
            RD:      state_next = write_q ? WR : RESP;
            WR:      state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane_align (
        .word       (buf_q),
        .addr_lo    (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (signed_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .store_word (mem_write_data)
    );

    assign req_ready       = (state == IDLE);
    assign mem_read        = (state == RD);
    // A write caught by reset must not reach memory.
    assign mem_write       = (state == WR) && !reset;
    assign mem_address     = {addr_q[31:2], 2'b00};
    assign resp_valid      = (state == RESP);
    assign resp_misaligned = resp_valid && flt_q[FLT_MISALIGNED];
    assign resp_range_err  = resp_valid && flt_q[FLT_RANGE];
    assign resp_rdata      = (resp_valid && !write_q && flt_q == '0) ? load_data : 32'h0;

endmodule
